// File: rtl/instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_queue
//  Purpose  : Prefetch queue between a one-cycle-latency program memory and
//             the decode stage. It issues sequential fetches while there is
//             room for every outstanding word. It buffers the returned words
//             in a small circular queue. On a taken branch it flushes the
//             queue and the in-flight word and restarts fetch.
//  Options  : FETCH_QUEUE_PERF_CNT_EN adds the fq_bubble_count output, a
//             saturating count of cycles where decode was ready but starved.
//  Revision : 1.0  initial release
// ============================================================================
module instruction_fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 17
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]         imem_data,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [INSTR_W-1:0]         dec_instr,
    output logic [ADDR_W-1:0]          dec_pc_plus1,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0]     fq_count
`ifdef FETCH_QUEUE_PERF_CNT_EN
    ,
    output logic [15:0]                fq_bubble_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  ret_pc_plus1;   // address+1 of the word arriving this cycle
    logic               inflight;       // a request was issued last cycle
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   occupancy;
    logic               push;
    logic               pop;

    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [ADDR_W-1:0]  pc_q    [DEPTH];

    // Fetch throttle: a request may only go out if every outstanding word
    // has a reserved slot. A redirect suppresses the request this cycle, and
    // the word returning now is killed instead of pushed.
    always_comb begin
        occupancy = count + CNT_W'(inflight);
        imem_req  = reset && !redirect && (occupancy < DEPTH_C);
        push      = inflight && !redirect;
        pop       = dec_valid && dec_ready;
    end

    assign imem_addr = fetch_pc;
    assign fq_count  = count;
    assign dec_valid = (count != '0);

    // Head presentation; a NOP is driven whenever nothing is valid.
    always_comb begin
        dec_instr    = '0;
        dec_pc_plus1 = '0;
        if (dec_valid) begin
            dec_instr    = instr_q[head];
            dec_pc_plus1 = pc_q[head];
        end
    end

    // Fetch PC, in-flight tracking, queue pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc     <= '0;
            ret_pc_plus1 <= '0;
            inflight     <= 1'b0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
        end else if (redirect) begin
            fetch_pc     <= redirect_pc;
            inflight     <= 1'b0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc     <= fetch_pc + ADDR_W'(1);
                ret_pc_plus1 <= fetch_pc + ADDR_W'(1);
            end
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage; contents are only meaningful between head and tail.
    always_ff @(posedge clock) begin
        if (push) begin
            instr_q[tail] <= imem_data;
            pc_q[tail]    <= ret_pc_plus1;
        end
    end

`ifdef FETCH_QUEUE_PERF_CNT_EN
    logic [15:0] bubble_cnt;

    // Decode-starvation counter: survives redirects, saturates at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (dec_ready && !dec_valid && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

    assign fq_bubble_count = bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/instruction_fetch_queue.md
INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, number of queue entries (power of two, 2..8).
REQ-002 SHALL provide parameter ADDR_W, default 8, program-memory address width.
REQ-003 SHALL provide parameter INSTR_W, default 17, instruction word width.
REQ-004 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset; one clock only.
REQ-006 SHALL have port imem_req  output  1  fetch request to program memory this cycle.
REQ-007 SHALL have port imem_addr  output  ADDR_W  fetch address; valid when imem_req=1.
REQ-008 SHALL have port imem_data  input  INSTR_W  instruction word returned exactly one cycle after imem_req.
REQ-009 SHALL have port dec_valid  output  1  head entry valid for decode.
REQ-010 SHALL have port dec_ready  input  1  decode accepts head entry (low = stall, data hazard).
REQ-011 SHALL have port dec_instr  output  INSTR_W  head instruction.
REQ-012 SHALL have port dec_pc_plus1  output  ADDR_W  head instruction address + 1, mod 2^ADDR_W.
REQ-013 SHALL have port redirect  input  1  taken branch/jump from execute; flush.
REQ-014 SHALL have port redirect_pc  input  ADDR_W  new fetch address; sampled when redirect=1.
REQ-015 SHALL have port fq_count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-016 SHALL hold an internal fetch_pc; imem_addr SHALL equal fetch_pc.
REQ-017 SHALL assert imem_req when redirect=0 and (fq_count + inflight) < DEPTH; inflight = imem_req registered from the previous cycle and not killed.
REQ-018 SHALL increment fetch_pc by 1 (wrap 8'hFF -> 8'h00) on every cycle imem_req=1.
REQ-019 SHALL push {imem_data, returned address + 1} into the tail the cycle after an unkilled request; dec_valid SHALL rise no earlier than 2 cycles after the request (no bypass).
REQ-020 SHALL pop the head on any cycle dec_valid=1 and dec_ready=1; dec_instr/dec_pc_plus1 SHALL hold stable while dec_valid=1 and dec_ready=0.
REQ-021 SHALL support simultaneous push and pop in one cycle with fq_count unchanged.
REQ-022 SHALL wrap head/tail pointers mod DEPTH; fq_count SHALL never exceed DEPTH nor underflow below 0.
REQ-023 SHALL, on redirect=1: empty the queue (fq_count=0, dec_valid=0 next cycle), load fetch_pc with redirect_pc, deassert imem_req that cycle, and kill the one in-flight return so it is not pushed.
REQ-024 SHALL give redirect priority over push, pop and stall in the same cycle; a pop coinciding with redirect SHALL still be counted as accepted by decode.
REQ-025 SHALL issue the first post-redirect request at redirect_pc in the cycle following redirect.
REQ-026 SHALL drive dec_instr to all-zero (NOP) whenever dec_valid=0.

Reset
REQ-027 SHALL, while reset=0, force fetch_pc=0, fq_count=0, pointers=0, inflight=0, imem_req=0, dec_valid=0, dec_instr=0, dec_pc_plus1=0, asynchronously.
REQ-028 SHALL issue the first request at address 0 on the first rising edge after reset deasserts; reset asserted mid-operation SHALL discard all queued and in-flight words.

Configuration
REQ-029 SHALL, when macro FETCH_QUEUE_PERF_CNT_EN is defined, add output fq_bubble_count (16 bits), counting cycles with dec_ready=1 and dec_valid=0, saturating at 16'hFFFF, cleared by reset and not by redirect.
REQ-030 SHALL, without FETCH_QUEUE_PERF_CNT_EN, omit fq_bubble_count port and counter logic entirely; all other behaviour identical.

Verification
REQ-031 Reset release, dec_ready=1, memory returns addr as data -> requests addr 0,1,2,...; dec_valid first high cycle 2 with dec_instr=0, dec_pc_plus1=1.
REQ-032 dec_ready=0 for 10 cycles -> fq_count saturates at 4, imem_req low once count+inflight=4, head holds addr 0 word; release -> words 0..3 popped in order, no loss/duplication.
REQ-033 redirect=1, redirect_pc=8'h40, with queue full and one inflight -> next cycle fq_count=0, dec_valid=0, inflight word not pushed; next request addr 8'h40; first dec_pc_plus1=8'h41.
REQ-034 redirect_pc=8'hFE, free-running -> requests FE, FF, 00, 01; dec_pc_plus1 sequence FF, 00, 01, 02.
REQ-035 reset asserted mid-stream with 3 entries queued -> immediately dec_valid=0, fq_count=0, imem_req=0; after release fetch restarts at addr 0.
REQ-036 With FETCH_QUEUE_PERF_CNT_EN: 5 cycles dec_ready=1 after reset (2 empty) -> fq_bubble_count=2; redirect -> count unchanged, then increments by 2 during refill.
